sensor_ctrl: RTL and testbench

SENSOR_CTRL -- requirements
Module: sensor_ctrl

---
 rtl/sensor_ctrl.sv | 109 ++++++++++
 tb/tb_sensor_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_ctrl.sv
// Image-sensor frame sequencer: erase, expose, gray-coded ADC ramp, two row reads.
// Define CONTINUOUS_MODE_EN to make frames repeat without init.
module sensor_ctrl #(
  parameter int ERASE_CYCLES = 5,
  parameter int EXP_MIN      = 2,
  parameter int EXP_MAX      = 30,
  parameter int EXP_DEFAULT  = 10,
  parameter int EXP_STEP     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        expInc,
  input  logic        expDec,
  output logic        erase,
  output logic        expose,
  output logic        convert,
  output logic [7:0]  adcCount,
  output logic        read1,
  output logic        read2,
  output logic        busy,
  output logic [15:0] expTime
);

  typedef enum logic [2:0] {
    IDLE, ERASE, EXPOSE, CONVERT, READ1, READ2
  } state_t;

`ifdef CONTINUOUS_MODE_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [15:0] lat_exp;
  logic [15:0] exp_n;
  logic [16:0] inc_sum;
  logic [15:0] inc_v, dec_v;
  logic        sample;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (init) state_n = ERASE;
      ERASE:   if (cnt == 16'(ERASE_CYCLES - 1)) state_n = EXPOSE;
      EXPOSE:  if (cnt == lat_exp - 16'd1) state_n = CONVERT;
      CONVERT: if (cnt[7:0] == 8'hFF) state_n = READ1;
      READ1:   state_n = READ2;
      READ2:   state_n = CONT ? ERASE : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    erase   = 1'b0;
    expose  = 1'b0;
    convert = 1'b0;
    read1   = 1'b0;
    read2   = 1'b0;
    busy    = (state != IDLE);
    unique case (state)
      ERASE:   erase   = 1'b1;
      EXPOSE:  expose  = 1'b1;
      CONVERT: convert = 1'b1;
      READ1:   read1   = 1'b1;
      READ2:   read2   = 1'b1;
      default: ;
    endcase
  end

  // Per-state cycle counter, cleared on every state change.
  assign cnt_n = (state_n != state || state == IDLE) ? '0 : cnt + 16'd1;

  assign inc_sum = {1'b0, expTime} + 17'(EXP_STEP);
  assign inc_v   = (inc_sum > 17'(EXP_MAX)) ? 16'(EXP_MAX) : inc_sum[15:0];
  assign dec_v   = (expTime < 16'(EXP_MIN + EXP_STEP)) ?
                   16'(EXP_MIN) : expTime - 16'(EXP_STEP);
  assign sample  = (state == IDLE) && !CONT;

  always_comb begin
    exp_n = expTime;
    if (sample && expInc && !expDec)      exp_n = inc_v;
    else if (sample && expDec && !expInc) exp_n = dec_v;
  end

  // Exposure latched with the already-updated value so init+inc applies first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      expTime  <= 16'(EXP_DEFAULT);
      lat_exp  <= 16'(EXP_DEFAULT);
      adcCount <= '0;
    end else begin
      cnt     <= cnt_n;
      expTime <= exp_n;
      if (state_n == ERASE && state != ERASE) lat_exp <= exp_n;
      adcCount <= (state_n == CONVERT) ?
                  (cnt_n[7:0] ^ (cnt_n[7:0] >> 1)) : 8'h00;
    end
  end

endmodule

// File: tb/tb_sensor_ctrl.sv
// Bench for sensor_ctrl: table-driven exposure updates, frame sequences,
// and randomized stimulus against a frame-phase reference model.
module tb_sensor_ctrl;

  localparam int E    = 5;
  localparam int DEF  = 10;
  localparam int MIN  = 2;
  localparam int MAX  = 30;
  localparam int STEP = 1;

  logic        clk = 1'b0;
  logic        reset, init, expInc, expDec;
  logic        erase, expose, convert, read1, read2, busy;
  logic [7:0]  adcCount;
  logic [15:0] expTime;

  sensor_ctrl dut (
    .clk(clk), .reset(reset), .init(init),
    .expInc(expInc), .expDec(expDec),
    .erase(erase), .expose(expose), .convert(convert),
    .adcCount(adcCount), .read1(read1), .read2(read2),
    .busy(busy), .expTime(expTime)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int bad  = 0;

  int m_exp, m_active, m_phase, m_T;

  function automatic logic [29:0] model_out();
    logic er, ex, cv, r1, r2, bz;
    logic [7:0] a;
    int p, b;
    er = 0; ex = 0; cv = 0; r1 = 0; r2 = 0; bz = 0; a = 8'h00;
    p = m_phase;
    if (m_active != 0) begin
      bz = 1;
      if (p <= E) er = 1;
      else if (p <= E + m_T) ex = 1;
      else if (p <= E + m_T + 256) begin
        cv = 1;
        b  = p - E - m_T - 1;
        a  = 8'(b ^ (b >> 1));
      end
      else if (p == E + m_T + 257) r1 = 1;
      else r2 = 1;
    end
    return {er, ex, cv, r1, r2, bz, a, 16'(m_exp)};
  endfunction

  task automatic check(input string name);
    logic [29:0] got, want;
    got  = {erase, expose, convert, read1, read2, busy, adcCount, expTime};
    want = model_out();
    vecs++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
    end
  endtask

  task automatic cmp(input string name, input int got, input int want);
    vecs++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic model_reset();
    m_exp = DEF; m_active = 0; m_phase = 0; m_T = DEF;
  endtask

  task automatic advance(input logic i, input logic u, input logic d);
    if (m_active == 0) begin
`ifndef CONTINUOUS_MODE_EN
      if (u && !d) m_exp = (m_exp + STEP > MAX) ? MAX : m_exp + STEP;
      else if (d && !u) m_exp = (m_exp - STEP < MIN) ? MIN : m_exp - STEP;
`endif
      if (i) begin m_active = 1; m_phase = 1; m_T = m_exp; end
    end else begin
      m_phase++;
      if (m_phase > E + m_T + 258) begin
`ifdef CONTINUOUS_MODE_EN
        m_phase = 1; m_T = m_exp;
`else
        m_active = 0; m_phase = 0;
`endif
      end
    end
  endtask

  task automatic step(input logic i, input logic u, input logic d);
    @(negedge clk);
    check("cycle");
    init = i; expInc = u; expDec = d;
    advance(i, u, d);
  endtask

  typedef struct {
    int   reps;
    logic u;
    logic d;
    int   exp_t;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int ne, nx, nc, n1, n2, lat, k, g;
    logic [7:0] adcq[$];
    logic r;

    tbl[0] = '{1,  1'b1, 1'b0, 11};
    tbl[1] = '{1,  1'b0, 1'b1, 10};
    tbl[2] = '{1,  1'b1, 1'b1, 10};
    tbl[3] = '{30, 1'b1, 1'b0, 30};
    tbl[4] = '{1,  1'b1, 1'b1, 30};
    tbl[5] = '{40, 1'b0, 1'b1, 2};
    tbl[6] = '{1,  1'b0, 1'b1, 2};
    tbl[7] = '{1,  1'b1, 1'b1, 2};
    tbl[8] = '{8,  1'b1, 1'b0, 10};

    reset = 1'b1; init = 0; expInc = 0; expDec = 0;
    model_reset();
    #3 check("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    foreach (tbl[t]) begin
      for (int j = 0; j < tbl[t].reps; j++) step(1'b0, tbl[t].u, tbl[t].d);
      step(1'b0, 1'b0, 1'b0);
`ifdef CONTINUOUS_MODE_EN
      cmp("tbl_exp", int'(expTime), DEF);
`else
      cmp("tbl_exp", int'(expTime), tbl[t].exp_t);
`endif
    end

    ne = 0; nx = 0; nc = 0; n1 = 0; n2 = 0; lat = -1;
    step(1'b1, 1'b0, 1'b0);
    for (k = 1; k <= 400; k++) begin
      step(1'b0, 1'b0, 1'b0);
      ne += int'(erase); nx += int'(expose); nc += int'(convert);
      n1 += int'(read1); n2 += int'(read2);
      if (read1 && read2) cmp("read_overlap", 1, 0);
      if (convert) adcq.push_back(adcCount);
      if (read2) begin lat = k; break; end
    end
    cmp("erase_len", ne, 5);
    cmp("expose_len", nx, 10);
    cmp("convert_len", nc, 256);
    cmp("read1_len", n1, 1);
    cmp("read2_len", n2, 1);
    cmp("latency", lat, 1 + E + 10 + 256 + 1);
    if (adcq.size() == 256) begin
      cmp("adc0", int'(adcq[0]), 8'h00);
      cmp("adc1", int'(adcq[1]), 8'h01);
      cmp("adc2", int'(adcq[2]), 8'h03);
      cmp("adc3", int'(adcq[3]), 8'h02);
      cmp("adc_last", int'(adcq[255]), 8'h80);
    end else cmp("adc_count", adcq.size(), 256);
    step(1'b0, 1'b0, 1'b0);
    cmp("adc_after", int'(adcCount), 0);
`ifdef CONTINUOUS_MODE_EN
    cmp("cont_erase", int'(erase), 1);
`else
    cmp("idle_busy", int'(busy), 0);
`endif

    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (k = 1; k <= 12 + 275; k++) begin
      if (k >= 7 && k <= 14) step(k[0], k[1], ~k[0]);
      else step(1'b0, 1'b0, 1'b0);
    end
`ifdef CONTINUOUS_MODE_EN
    cmp("exp_ignored", int'(expTime), DEF);
`else
    cmp("exp_ignored", int'(expTime), 12);
    cmp("no_restart", int'(busy), 0);
`endif

    if (m_active == 0) step(1'b1, 1'b0, 1'b0);
    k = 0;
    while (m_phase != E + m_T + 101 && k < 600) begin
      step(1'b0, 1'b0, 1'b0);
      k++;
    end
    @(negedge clk);
    check("cvt100");
    g = 100 ^ (100 >> 1);
    cmp("cvt100_adc", int'(adcCount), g);
    #2 reset = 1'b1;
    model_reset();
    #1 check("reset_mid_convert");
    @(negedge clk) reset = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    for (k = 0; k < 280; k++) step(1'b0, 1'b0, 1'b0);

    for (k = 0; k < 4000; k++) begin
      r = ($urandom_range(0, 24) == 0);
      step(r, ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end

endmodule
